// File: rtl/quick_mem_responder_if.sv
// Bus bundle between the quick CPU / host and quick_mem_responder.
// With QUICK_MEM_WP_EN defined the bundle also carries wp_err.
interface quick_mem_responder_if #(
    parameter int AW = 8
);
    logic [7:0]    bus_ad;
    logic          mem_read;
    logic          mem_write;
    logic [7:0]    rdata;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          host_busy;
    logic          proto_err;
`ifdef QUICK_MEM_WP_EN
    logic          wp_err;

    modport master (
        output bus_ad, mem_read, mem_write, host_we, host_addr, host_wdata,
        input  rdata, host_rdata, host_busy, proto_err, wp_err
    );
    modport slave (
        input  bus_ad, mem_read, mem_write, host_we, host_addr, host_wdata,
        output rdata, host_rdata, host_busy, proto_err, wp_err
    );
`else
    modport master (
        output bus_ad, mem_read, mem_write, host_we, host_addr, host_wdata,
        input  rdata, host_rdata, host_busy, proto_err
    );
    modport slave (
        input  bus_ad, mem_read, mem_write, host_we, host_addr, host_wdata,
        output rdata, host_rdata, host_busy, proto_err
    );
`endif
endinterface

// File: rtl/quick_mem_responder.sv
// Memory-side responder for the quick CPU bus: combinational reads, two-cycle stores,
// host preload/inspect port. Optional CPU write protection under QUICK_MEM_WP_EN.
//
// state     | meaning
// S_IDLE    | serve reads, capture store address, accept host writes
// S_WR_DATA | bus_ad carries store data; commit to addr_q this edge
module quick_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int PROTECT_TOP = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    quick_mem_responder_if.slave  mem_if
);
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_WR_DATA = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_addr_q;
    logic [7:0]    r_host_rdata;
    logic          r_proto_err;

    logic          w_rd_en;
    logic          w_addr_cap;
    logic          w_wr_phase;
    logic          w_proto_set;
    logic          w_host_ok;
    logic          w_host_commit;
    logic          w_cpu_commit;
    logic [AW-1:0] w_bus_idx;

    assign w_bus_idx = mem_if.bus_ad[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_addr_cap  = 1'b0;
        w_wr_phase  = 1'b0;
        w_proto_set = 1'b0;
        w_host_ok   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_host_ok = !mem_if.mem_read && !mem_if.mem_write;
                if (mem_if.mem_read && mem_if.mem_write) begin
                    w_proto_set = 1'b1;
                end else if (mem_if.mem_read) begin
                    w_rd_en = 1'b1;
                end else if (mem_if.mem_write) begin
                    w_addr_cap  = 1'b1;
                    w_state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                // Data cycle is unconditional; a strobe here is a CPU protocol bug.
                w_wr_phase  = 1'b1;
                w_proto_set = mem_if.mem_read || mem_if.mem_write;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_host_commit    = mem_if.host_we && w_host_ok;
    assign mem_if.host_busy = mem_if.host_we && !w_host_ok;
    assign mem_if.rdata     = w_rd_en ? r_mem[w_bus_idx] : 8'h00;

`ifdef QUICK_MEM_WP_EN
    logic r_wp_err;
    logic w_wp_hit;

    assign w_wp_hit     = w_wr_phase && ({{(32-AW){1'b0}}, r_addr_q} < PROTECT_TOP);
    assign w_cpu_commit = w_wr_phase && !w_wp_hit;
    assign mem_if.wp_err = r_wp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp_err <= 1'b0;
        end else if (w_wp_hit) begin
            r_wp_err <= 1'b1;
        end
    end
`else
    assign w_cpu_commit = w_wr_phase;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q     <= '0;
            r_host_rdata <= 8'h00;
            r_proto_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_host_rdata <= r_mem[mem_if.host_addr];
            if (w_addr_cap) begin
                r_addr_q <= w_bus_idx;
            end
            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end
            // CPU commits only in WR_DATA, host only in IDLE: never both in one cycle.
            if (w_cpu_commit) begin
                r_mem[r_addr_q] <= mem_if.bus_ad;
            end
            if (w_host_commit) begin
                r_mem[mem_if.host_addr] <= mem_if.host_wdata;
            end
        end
    end

    assign mem_if.host_rdata = r_host_rdata;
    assign mem_if.proto_err  = r_proto_err;
endmodule

// File: tb/tb_quick_mem_responder.sv
// Bench for quick_mem_responder: 256-byte instance plus a 16-byte instance for wrap.
// Build with or without QUICK_MEM_WP_EN; expectations follow the macro.
module tb_quick_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quick_mem_responder_if #(.AW(8)) m8 ();
    quick_mem_responder_if #(.AW(4)) m16 ();

    quick_mem_responder #(.DEPTH(256), .AW(8), .PROTECT_TOP(16)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (m8)
    );

    quick_mem_responder #(.DEPTH(16), .AW(4), .PROTECT_TOP(0)) u_dut16 (
        .clk    (clk),
        .rst    (rst),
        .mem_if (m16)
    );

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_mem [256];
    logic [7:0] m16_mem [16];
    logic       m_proto;
    logic       m_wp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m8.bus_ad = 8'h00; m8.mem_read = 1'b0; m8.mem_write = 1'b0;
        m8.host_we = 1'b0; m8.host_addr = 8'h00; m8.host_wdata = 8'h00;
        m16.bus_ad = 8'h00; m16.mem_read = 1'b0; m16.mem_write = 1'b0;
        m16.host_we = 1'b0; m16.host_addr = 4'h0; m16.host_wdata = 8'h00;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) m16_mem[i] = 8'h00;
        m_proto = 1'b0;
        m_wp    = 1'b0;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        m8.host_we = 1'b1; m8.host_addr = a; m8.host_wdata = d;
        tick();
        m8.host_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic cpu_store(input logic [7:0] a, input logic [7:0] d);
        m8.bus_ad = a; m8.mem_write = 1'b1;
        tick();
        m8.mem_write = 1'b0; m8.bus_ad = d;
        tick();
        m8.bus_ad = 8'h00;
`ifdef QUICK_MEM_WP_EN
        if (a < 8'h10) m_wp = 1'b1;
        else m_mem[a] = d;
`else
        m_mem[a] = d;
`endif
    endtask

    // Observe host_rdata one edge after presenting the address.
    task automatic host_check(input logic [7:0] a, input string tag);
        m8.host_addr = a;
        sb.push_back('{tag: tag, val: m_mem[a]});
        tick();
        e = sb.pop_front(); checks++;
        if (m8.host_rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.host_rdata, e.val);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick(); tick();
        model_reset();
        sb.push_back('{tag: "rst_host_rdata", val: 8'h00});
        sb.push_back('{tag: "rst_proto_err", val: {7'b0, m_proto}});
        e = sb.pop_front(); checks++;
        if (m8.host_rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.host_rdata, e.val);
        end
        e = sb.pop_front(); checks++;
        if ({7'b0, m8.proto_err} !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.proto_err, e.val);
        end
`ifdef QUICK_MEM_WP_EN
        checks++;
        if (m8.wp_err !== 1'b0) begin
            errors++; $display("FAIL rst_wp_err got %b exp 0", m8.wp_err);
        end
`endif
        rst = 1'b0;
        host_check(8'h7F, "rst_array_zero");
    endtask

    task automatic test_read();
        host_write(8'h00, 8'h05);
        m8.bus_ad = 8'h00; m8.mem_read = 1'b1;
        sb.push_back('{tag: "rd_same_cycle", val: m_mem[8'h00]});
        #1 e = sb.pop_front(); checks++;
        if (m8.rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.rdata, e.val);
        end
        tick();
        m8.mem_read = 1'b0;
        sb.push_back('{tag: "rd_idle_zero", val: 8'h00});
        #1 e = sb.pop_front(); checks++;
        if (m8.rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.rdata, e.val);
        end
    endtask

    task automatic test_store();
        m8.host_addr = 8'h20;
        m8.bus_ad = 8'h20; m8.mem_write = 1'b1;
        tick();
        m8.mem_write = 1'b0; m8.bus_ad = 8'hA7;
        sb.push_back('{tag: "wr_data_rdata", val: 8'h00});
        #1 e = sb.pop_front(); checks++;
        if (m8.rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.rdata, e.val);
        end
        sb.push_back('{tag: "host_rbw_old", val: m_mem[8'h20]});
        tick();
        m_mem[8'h20] = 8'hA7;
        e = sb.pop_front(); checks++;
        if (m8.host_rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.host_rdata, e.val);
        end
        m8.bus_ad = 8'h00;
        host_check(8'h20, "store_host_rd");
        m8.bus_ad = 8'h20; m8.mem_read = 1'b1;
        sb.push_back('{tag: "store_cpu_rd", val: m_mem[8'h20]});
        #1 e = sb.pop_front(); checks++;
        if (m8.rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.rdata, e.val);
        end
        tick();
        m8.mem_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [3];
        logic [7:0] datas [3];
        addrs = '{8'h21, 8'h22, 8'hFF};
        datas = '{8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 3; i++) cpu_store(addrs[i], datas[i]);
        // Read directly after the last commit edge, then the others.
        for (int i = 2; i >= 0; i--) begin
            m8.bus_ad = addrs[i]; m8.mem_read = 1'b1;
            sb.push_back('{tag: $sformatf("b2b_rd_%0d", i), val: m_mem[addrs[i]]});
            #1 e = sb.pop_front(); checks++;
            if (m8.rdata !== e.val) begin
                errors++; $display("FAIL %s got %h exp %h", e.tag, m8.rdata, e.val);
            end
            tick();
        end
        m8.mem_read = 1'b0;
    endtask

    task automatic test_proto();
        host_write(8'h10, 8'h5A);
        m8.bus_ad = 8'h10; m8.mem_read = 1'b1; m8.mem_write = 1'b1;
        sb.push_back('{tag: "proto_both_rdata", val: 8'h00});
        #1 e = sb.pop_front(); checks++;
        if (m8.rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.rdata, e.val);
        end
        tick();
        m_proto = 1'b1;
        m8.mem_read = 1'b0; m8.mem_write = 1'b0;
        checks++;
        if (m8.proto_err !== m_proto) begin
            errors++; $display("FAIL proto_both_flag got %b exp %b", m8.proto_err, m_proto);
        end
        host_check(8'h10, "proto_both_unchanged");
        // Second case from a clean flag: read strobe in the data cycle.
        rst = 1'b1; tick(); rst = 1'b0; model_reset();
        checks++;
        if (m8.proto_err !== m_proto) begin
            errors++; $display("FAIL proto_cleared got %b exp %b", m8.proto_err, m_proto);
        end
        m8.bus_ad = 8'h12; m8.mem_write = 1'b1;
        tick();
        m8.mem_write = 1'b0; m8.mem_read = 1'b1; m8.bus_ad = 8'h66;
        sb.push_back('{tag: "proto_wr_rdata", val: 8'h00});
        #1 e = sb.pop_front(); checks++;
        if (m8.rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m8.rdata, e.val);
        end
        tick();
        m8.mem_read = 1'b0; m8.bus_ad = 8'h00;
        m_mem[8'h12] = 8'h66; m_proto = 1'b1;
        checks++;
        if (m8.proto_err !== m_proto) begin
            errors++; $display("FAIL proto_wr_flag got %b exp %b", m8.proto_err, m_proto);
        end
        host_check(8'h12, "proto_wr_commit");
    endtask

    task automatic test_host_busy();
        m8.host_we = 1'b1; m8.host_addr = 8'h40; m8.host_wdata = 8'hEE;
        m8.bus_ad = 8'h00; m8.mem_read = 1'b1;
        #1 checks++;
        if (m8.host_busy !== 1'b1) begin
            errors++; $display("FAIL busy_read got %b exp 1", m8.host_busy);
        end
        tick();
        m8.mem_read = 1'b0; m8.mem_write = 1'b1; m8.bus_ad = 8'h41;
        #1 checks++;
        if (m8.host_busy !== 1'b1) begin
            errors++; $display("FAIL busy_write_strobe got %b exp 1", m8.host_busy);
        end
        tick();
        m8.mem_write = 1'b0; m8.bus_ad = 8'h3C;
        #1 checks++;
        if (m8.host_busy !== 1'b1) begin
            errors++; $display("FAIL busy_wr_data got %b exp 1", m8.host_busy);
        end
        tick();
        m_mem[8'h41] = 8'h3C;
        m8.host_we = 1'b0; m8.bus_ad = 8'h00;
        host_check(8'h40, "busy_discarded");
        host_check(8'h41, "busy_cpu_commit");
        m8.host_we = 1'b1; m8.host_addr = 8'h42; m8.host_wdata = 8'h99;
        #1 checks++;
        if (m8.host_busy !== 1'b0) begin
            errors++; $display("FAIL busy_idle got %b exp 0", m8.host_busy);
        end
        tick();
        m8.host_we = 1'b0; m_mem[8'h42] = 8'h99;
        host_check(8'h42, "host_write_ok");
    endtask

    task automatic test_reset_mid_write();
        m8.bus_ad = 8'h30; m8.mem_write = 1'b1;
        tick();
        m8.mem_write = 1'b0; m8.bus_ad = 8'hBB; rst = 1'b1;
        tick();
        rst = 1'b0; model_reset();
        m8.bus_ad = 8'h77;
        checks++;
        if (m8.proto_err !== m_proto) begin
            errors++; $display("FAIL midrst_proto got %b exp %b", m8.proto_err, m_proto);
        end
        tick();
        m8.bus_ad = 8'h00;
        host_check(8'h30, "midrst_dropped");
        m8.host_we = 1'b1; m8.host_addr = 8'h31; m8.host_wdata = 8'h12;
        #1 checks++;
        if (m8.host_busy !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got %b exp 0", m8.host_busy);
        end
        tick();
        m8.host_we = 1'b0; m_mem[8'h31] = 8'h12;
        host_check(8'h31, "midrst_host_wr");
    endtask

    task automatic test_wrap();
        m16.bus_ad = 8'h35; m16.mem_write = 1'b1;
        tick();
        m16.mem_write = 1'b0; m16.bus_ad = 8'h9C;
        tick();
        m16_mem[5] = 8'h9C;
        m16.bus_ad = 8'h00; m16.host_addr = 4'h5;
        sb.push_back('{tag: "wrap_host_rd", val: m16_mem[5]});
        tick();
        e = sb.pop_front(); checks++;
        if (m16.host_rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m16.host_rdata, e.val);
        end
        m16.bus_ad = 8'hE5; m16.mem_read = 1'b1;
        sb.push_back('{tag: "wrap_cpu_rd", val: m16_mem[5]});
        #1 e = sb.pop_front(); checks++;
        if (m16.rdata !== e.val) begin
            errors++; $display("FAIL %s got %h exp %h", e.tag, m16.rdata, e.val);
        end
        tick();
        m16.mem_read = 1'b0; m16.bus_ad = 8'h00;
    endtask

    task automatic test_write_protect();
        host_write(8'h03, 8'h11);
        host_write(8'h0F, 8'h22);
        cpu_store(8'h03, 8'hFF);
        cpu_store(8'h0F, 8'hEE);
        cpu_store(8'h10, 8'h33);
        host_check(8'h03, "wp_addr03");
        host_check(8'h0F, "wp_addr0f");
        host_check(8'h10, "wp_addr10");
`ifdef QUICK_MEM_WP_EN
        checks++;
        if (m8.wp_err !== m_wp) begin
            errors++; $display("FAIL wp_err got %b exp %b", m8.wp_err, m_wp);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        test_reset();
        test_read();
        test_store();
        test_back_to_back();
        test_proto();
        test_host_busy();
        test_reset_mid_write();
        test_wrap();
        test_write_protect();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL sb_drained got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
